// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR filter and its coefficient loader:
//   CW_DEF     - default coefficient width (filter CIN width)
//   AW_DEF     - default coefficient address width (filter CADDR width)
//   CSUM_W     - width of the load checksum
//   loader_state_e - coefficient loader FSM state encoding
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int CW_DEF = 20;
  localparam int AW_DEF = 11;
  localparam int CSUM_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FIN   = 2'd3
  } loader_state_e;

endpackage : fir_pkg

// File: rtl/coef_loader.sv
// -----------------------------------------------------------------------------
// coef_loader
// Streams N_WORDS coefficient words from a valid/ready source into the FIR
// filter's coefficient port, holding the filter idle for the duration of the
// load and reporting a modulo-2^24 checksum of each completed load.
//
// Ports
//   clk          in   single clock (filter fast-clock domain)
//   reset        in   synchronous, active-high reset
//   start        in   one-cycle request to begin a load (honoured in IDLE only)
//   abort        in   one-cycle request to cancel a load (honoured in LOAD only)
//   s_data       in   [CW] incoming coefficient word
//   s_valid      in   s_data is valid
//   s_ready      out  loader accepts s_data (high in LOAD)
//   CIN          out  [CW] coefficient to the filter
//   CADDR        out  [AW] coefficient address to the filter
//   CLOAD        out  filter write strobe, one cycle after acceptance
//   busy         out  load in progress
//   filter_hold  out  hold the filter idle (equal to busy)
//   done         out  one-cycle pulse on load completion
//   aborted      out  one-cycle pulse on load cancellation
//   csum         out  [24] sum of the words of the last completed load
// -----------------------------------------------------------------------------
module coef_loader
  import fir_pkg::*;
#(
  parameter int N_WORDS = 2048,
  parameter int CW      = CW_DEF,
  parameter int AW      = AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CW-1:0]     s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [CW-1:0]     CIN,
  output logic [AW-1:0]     CADDR,
  output logic              CLOAD,
  output logic              busy,
  output logic              filter_hold,
  output logic              done,
  output logic              aborted,
  output logic [CSUM_W-1:0] csum
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N_WORDS - 1);

  loader_state_e     state_q, state_d;
  logic [CW-1:0]     cin_q;
  logic [AW-1:0]     caddr_q;
  logic              cload_q;
  logic              aborted_q;
  logic [AW-1:0]     idx_q;
  logic [CSUM_W-1:0] acc_q;
  logic [CSUM_W-1:0] csum_q;

  logic accept;
  logic load_word;
  logic in_load;

  assign in_load   = (state_q == ST_LOAD);
  assign accept    = in_load && s_valid;
  // Abort wins over a coincident acceptance: that word is dropped entirely.
  assign load_word = accept && !abort;

  // NOTE: every signal assigned in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (abort)                            state_d = ST_IDLE;
        else if (accept && idx_q == LAST_IDX) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every register here is a control/datapath flop (no RAM), so all
      // are cleared; a pending CLOAD is killed by clearing cload_q.
      state_q   <= ST_IDLE;
      cin_q     <= '0;
      caddr_q   <= '0;
      cload_q   <= 1'b0;
      aborted_q <= 1'b0;
      idx_q     <= '0;
      acc_q     <= '0;
      csum_q    <= '0;
    end else begin
      state_q   <= state_d;
      cload_q   <= load_word;
      aborted_q <= in_load && abort;

      if (state_q == ST_IDLE && start) begin
        idx_q <= '0;
        acc_q <= '0;
      end else if (load_word) begin
        cin_q   <= s_data;
        caddr_q <= idx_q;
        acc_q   <= acc_q + CSUM_W'(s_data);
        // The last index leaves LOAD, so the counter stops rather than wraps.
        if (idx_q != LAST_IDX) idx_q <= idx_q + AW'(1);
      end

      // The accumulator already holds the final word when FLUSH is reached.
      if (state_q == ST_FLUSH) csum_q <= acc_q;
    end
  end

  assign s_ready     = in_load;
  assign CIN         = cin_q;
  assign CADDR       = caddr_q;
  assign CLOAD       = cload_q;
  assign busy        = (state_q != ST_IDLE);
  assign filter_hold = busy;
  assign done        = (state_q == ST_FIN);
  assign aborted     = aborted_q;
  assign csum        = csum_q;

endmodule : coef_loader

// File: tb/tb_coef_loader.sv
// -----------------------------------------------------------------------------
// tb_coef_loader
// Directed bench for coef_loader: one instance with N_WORDS=4 and one with
// N_WORDS=1. Expected coefficient writes are queued when a word is driven and
// popped whenever an instance raises CLOAD.
// -----------------------------------------------------------------------------
module tb_coef_loader;

  typedef struct packed {
    logic [10:0] addr;
    logic [19:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  // N_WORDS = 4 instance
  logic        a_start, a_abort, a_s_valid;
  logic [19:0] a_s_data;
  logic        a_s_ready, a_cload, a_busy, a_hold, a_done, a_aborted;
  logic [19:0] a_cin;
  logic [10:0] a_caddr;
  logic [23:0] a_csum;

  // N_WORDS = 1 instance
  logic        b_start, b_abort, b_s_valid;
  logic [19:0] b_s_data;
  logic        b_s_ready, b_cload, b_busy, b_hold, b_done, b_aborted;
  logic [19:0] b_cin;
  logic [10:0] b_caddr;
  logic [23:0] b_csum;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;

  coef_loader #(.N_WORDS(4), .CW(20), .AW(11)) u_dut_a (
    .clk(clk), .reset(reset), .start(a_start), .abort(a_abort),
    .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .CIN(a_cin), .CADDR(a_caddr), .CLOAD(a_cload), .busy(a_busy),
    .filter_hold(a_hold), .done(a_done), .aborted(a_aborted), .csum(a_csum)
  );

  coef_loader #(.N_WORDS(1), .CW(20), .AW(11)) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
    .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .CIN(b_cin), .CADDR(b_caddr), .CLOAD(b_cload), .busy(b_busy),
    .filter_hold(b_hold), .done(b_done), .aborted(b_aborted), .csum(b_csum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge and score any write.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (a_cload === 1'b1) begin
      if (qa.size() == 0) check("a_cload_unexpected", 32'(a_cload), 32'd0);
      else begin
        e = qa.pop_front();
        check("a_caddr", 32'(a_caddr), 32'(e.addr));
        check("a_cin",   32'(a_cin),   32'(e.data));
      end
    end
    if (b_cload === 1'b1) begin
      if (qb.size() == 0) check("b_cload_unexpected", 32'(b_cload), 32'd0);
      else begin
        e = qb.pop_front();
        check("b_caddr", 32'(b_caddr), 32'(e.addr));
        check("b_cin",   32'(b_cin),   32'(e.data));
      end
    end
  endtask

  // Drive one word into instance A with s_valid high and queue its write.
  task automatic a_word(input logic [10:0] addr, input logic [19:0] data);
    a_s_valid = 1'b1;
    a_s_data  = data;
    qa.push_back('{addr: addr, data: data});
    step();
    check("a_cload_word", 32'(a_cload), 32'd1);
  endtask

  task automatic a_all_zero(input string tag);
    check({tag, "_cin"},     32'(a_cin),     32'd0);
    check({tag, "_caddr"},   32'(a_caddr),   32'd0);
    check({tag, "_cload"},   32'(a_cload),   32'd0);
    check({tag, "_busy"},    32'(a_busy),    32'd0);
    check({tag, "_hold"},    32'(a_hold),    32'd0);
    check({tag, "_done"},    32'(a_done),    32'd0);
    check({tag, "_aborted"}, 32'(a_aborted), 32'd0);
    check({tag, "_csum"},    32'(a_csum),    32'd0);
    check({tag, "_s_ready"}, 32'(a_s_ready), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; a_s_valid = 1'b0; a_s_data = '0;
    b_start = 1'b0; b_abort = 1'b0; b_s_valid = 1'b0; b_s_data = '0;
    step();
    step();
    a_all_zero("rst");
    check("rst_b_busy", 32'(b_busy), 32'd0);
    check("rst_b_csum", 32'(b_csum), 32'd0);
    reset = 1'b0;
    step();

    // ---- full load, s_valid held high ----
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    check("full_busy",    32'(a_busy),    32'd1);
    check("full_hold",    32'(a_hold),    32'd1);
    check("full_s_ready", 32'(a_s_ready), 32'd1);
    a_word(11'd0, 20'h00001);
    a_word(11'd1, 20'h00002);
    a_word(11'd2, 20'hFFFFF);
    a_word(11'd3, 20'h00010);       // now in FLUSH with the last CLOAD
    a_s_valid = 1'b0;
    check("full_flush_s_ready", 32'(a_s_ready), 32'd0);
    check("full_flush_done",    32'(a_done),    32'd0);
    step();                         // FIN
    check("full_done",      32'(a_done),  32'd1);
    check("full_csum",      32'(a_csum),  32'h100012);
    check("full_fin_busy",  32'(a_busy),  32'd1);
    step();                         // IDLE
    check("full_idle_busy", 32'(a_busy),  32'd0);
    check("full_idle_done", 32'(a_done),  32'd0);
    check("full_csum_hold", 32'(a_csum),  32'h100012);
    check("full_q_empty",   32'(qa.size()), 32'd0);

    // ---- abort ignored in IDLE ----
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    check("idle_abort_pulse", 32'(a_aborted), 32'd0);
    check("idle_abort_busy",  32'(a_busy),    32'd0);

    // ---- backpressure gap between words 1 and 2 ----
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    a_word(11'd0, 20'hAAAAA);
    a_word(11'd1, 20'h55555);
    a_s_valid = 1'b0;
    a_s_data  = 20'h0BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("gap_cload", 32'(a_cload), 32'd0);
      check("gap_caddr", 32'(a_caddr), 32'd1);
      check("gap_cin",   32'(a_cin),   32'h55555);
    end
    a_word(11'd2, 20'h00003);
    a_word(11'd3, 20'h00004);
    a_s_valid = 1'b0;
    step();
    check("gap_done", 32'(a_done), 32'd1);
    check("gap_csum", 32'(a_csum), 32'h100006);
    step();
    check("gap_q_empty", 32'(qa.size()), 32'd0);

    // ---- abort coincident with acceptance of word 2 ----
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    a_word(11'd0, 20'h11111);
    a_word(11'd1, 20'h22222);
    a_s_valid = 1'b1;
    a_s_data  = 20'h33333;
    a_abort   = 1'b1;
    step();
    a_abort   = 1'b0;
    a_s_valid = 1'b0;
    check("abort_cload",   32'(a_cload),   32'd0);
    check("abort_pulse",   32'(a_aborted), 32'd1);
    check("abort_busy",    32'(a_busy),    32'd0);
    check("abort_done",    32'(a_done),    32'd0);
    step();
    check("abort_pulse_end", 32'(a_aborted), 32'd0);
    check("abort_no_done",   32'(a_done),    32'd0);
    check("abort_cload2",    32'(a_cload),   32'd0);
    check("abort_csum",      32'(a_csum),    32'h100006);
    check("abort_q_empty",   32'(qa.size()), 32'd0);

    // ---- start in LOAD and FIN ignored; abort in FLUSH ignored ----
    a_start = 1'b1;
    step();
    a_word(11'd0, 20'h00001);       // start still high while in LOAD
    a_start = 1'b0;
    a_word(11'd1, 20'h00001);
    a_word(11'd2, 20'h00001);
    a_word(11'd3, 20'h00001);       // FLUSH
    a_s_valid = 1'b0;
    a_abort   = 1'b1;
    step();                         // FIN despite abort
    a_abort   = 1'b0;
    check("busy_fin_done",    32'(a_done),    32'd1);
    check("busy_flush_abort", 32'(a_aborted), 32'd0);
    check("busy_csum",        32'(a_csum),    32'd4);
    a_start = 1'b1;
    step();                         // IDLE, start in FIN ignored
    a_start = 1'b0;
    check("busy_fin_start", 32'(a_busy), 32'd0);
    step();
    check("busy_still_idle", 32'(a_busy), 32'd0);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    a_word(11'd0, 20'h77777);       // fresh load starts at CADDR 0
    a_word(11'd1, 20'h00000);
    a_word(11'd2, 20'h00000);
    a_word(11'd3, 20'h00000);
    a_s_valid = 1'b0;
    step();
    check("fresh_csum", 32'(a_csum), 32'h077777);
    step();

    // ---- reset mid-load with a word being accepted ----
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    a_word(11'd0, 20'h0ABCD);
    a_word(11'd1, 20'h0DCBA);
    a_s_valid = 1'b1;
    a_s_data  = 20'h0F00D;
    reset     = 1'b1;
    step();
    a_all_zero("midrst");
    reset     = 1'b0;
    a_s_valid = 1'b0;
    step();
    check("midrst_cload", 32'(a_cload), 32'd0);
    check("midrst_busy",  32'(a_busy),  32'd0);
    check("midrst_q_empty", 32'(qa.size()), 32'd0);

    // ---- N_WORDS = 1 ----
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    check("one_s_ready", 32'(b_s_ready), 32'd1);
    b_s_valid = 1'b1;
    b_s_data  = 20'h12345;
    qb.push_back('{addr: 11'd0, data: 20'h12345});
    step();
    b_s_valid = 1'b0;
    check("one_cload",   32'(b_cload),   32'd1);
    check("one_s_ready_flush", 32'(b_s_ready), 32'd0);
    step();
    check("one_done",  32'(b_done),  32'd1);
    check("one_csum",  32'(b_csum),  32'h012345);
    check("one_cload_fin", 32'(b_cload), 32'd0);
    step();
    check("one_idle_busy", 32'(b_busy), 32'd0);
    check("one_q_empty",   32'(qb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_coef_loader
